// File: rtl/sip_out_fifo_if.sv
// Write/read handshake, data lanes and status flags between the PHY output-path controller and sip_out_fifo.
// OVERFLOW/UNDERFLOW are present only when SIP_OUT_FIFO_ERR_FLAGS_EN is defined.
interface sip_out_fifo_if;
    logic       WREN;
    logic       RDEN;
    logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7, D8, D9;
    logic [3:0] Q0, Q1, Q2, Q3, Q4, Q7, Q8, Q9;
    logic [7:0] Q5, Q6;
    logic       EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL;
`ifdef SIP_OUT_FIFO_ERR_FLAGS_EN
    logic       OVERFLOW, UNDERFLOW;
`endif

    modport master (
        output WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
`ifdef SIP_OUT_FIFO_ERR_FLAGS_EN
        input  OVERFLOW, UNDERFLOW,
`endif
        input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
        input  EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL
    );

    modport slave (
        input  WREN, RDEN, D0, D1, D2, D3, D4, D5, D6, D7, D8, D9,
`ifdef SIP_OUT_FIFO_ERR_FLAGS_EN
        output OVERFLOW, UNDERFLOW,
`endif
        output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, Q9,
        output EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL
    );
endinterface

// File: rtl/sip_out_fifo.sv
// 8-deep x 80-bit output FIFO for the PHY output path, one beat (4_X_4) or two nibble beats (8_X_4) per word.
// Optional sticky OVERFLOW/UNDERFLOW outputs are compiled in with SIP_OUT_FIFO_ERR_FLAGS_EN.
module sip_out_fifo #(
    parameter int    ALMOST_EMPTY_VALUE = 1,
    parameter int    ALMOST_FULL_VALUE  = 1,
    parameter string ARRAY_MODE         = "8_X_4",
    parameter string OUTPUT_DISABLE     = "FALSE"
) (
    input logic           CLK,
    input logic           RESET_N,
    sip_out_fifo_if.slave fifo
);

    localparam int DEPTH    = 8;
    localparam bit MODE_8X4 = (ARRAY_MODE == "8_X_4");
    localparam bit OUT_DIS  = (OUTPUT_DISABLE == "TRUE");
    // Q lanes 0..4 and 7..9 are nibble wide; these are their source lane numbers.
    localparam int NIB_LANE [8] = '{0, 1, 2, 3, 4, 7, 8, 9};

    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > 2) begin : g_bad_ae
        $fatal(1, "sip_out_fifo: ALMOST_EMPTY_VALUE must be 1 or 2");
    end
    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > 2) begin : g_bad_af
        $fatal(1, "sip_out_fifo: ALMOST_FULL_VALUE must be 1 or 2");
    end
    if (ARRAY_MODE != "8_X_4" && ARRAY_MODE != "4_X_4") begin : g_bad_mode
        $fatal(1, "sip_out_fifo: ARRAY_MODE must be \"8_X_4\" or \"4_X_4\"");
    end
    if (OUTPUT_DISABLE != "TRUE" && OUTPUT_DISABLE != "FALSE") begin : g_bad_dis
        $fatal(1, "sip_out_fifo: OUTPUT_DISABLE must be \"TRUE\" or \"FALSE\"");
    end

    typedef logic [9:0][7:0] word_t;

    word_t           mem_q [DEPTH];
    word_t           wr_word;
    word_t           rd_word;
    logic [2:0]      wr_ptr_q, wr_ptr_d;
    logic [2:0]      rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic            phase_q, phase_d;
    logic [7:0][3:0] q_nib_q, q_nib_d;
    logic [1:0][7:0] q_byte_q, q_byte_d;
    logic            empty_q, full_q, aempty_q, afull_q;
    logic            empty_d, full_d, aempty_d, afull_d;
    logic            wr_acc, rd_acc, pop, hi_sel;

    assign wr_word = {fifo.D9, fifo.D8, fifo.D7, fifo.D6, fifo.D5,
                      fifo.D4, fifo.D3, fifo.D2, fifo.D1, fifo.D0};
    assign rd_word = mem_q[rd_ptr_q];

    assign wr_acc = fifo.WREN & ~full_q;
    assign rd_acc = fifo.RDEN & ~empty_q;
    // In 8_X_4 a word leaves the FIFO only on its second (high-nibble) beat.
    assign pop    = rd_acc & (~MODE_8X4 | phase_q);
    assign hi_sel = MODE_8X4 & phase_q;

    always_comb begin
        // NOTE: every always_comb output takes a default first, so no path leaves it unassigned and infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        q_nib_d  = q_nib_q;
        q_byte_d = q_byte_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + 3'd1;
        if (pop)    rd_ptr_d = rd_ptr_q + 3'd1;

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        phase_d = MODE_8X4 ? (phase_q ^ rd_acc) : 1'b0;

        for (int k = 0; k < 8; k++) begin
            if (OUT_DIS)
                q_nib_d[k] = 4'h0;
            else if (rd_acc)
                q_nib_d[k] = hi_sel ? rd_word[NIB_LANE[k]][7:4] : rd_word[NIB_LANE[k]][3:0];
        end

        for (int j = 0; j < 2; j++) begin
            if (OUT_DIS)
                q_byte_d[j] = 8'h00;
            else if (rd_acc) begin
                if (MODE_8X4)
                    q_byte_d[j] = {4'h0, hi_sel ? rd_word[5+j][7:4] : rd_word[5+j][3:0]};
                else
                    q_byte_d[j] = rd_word[5+j];
            end
        end

        empty_d  = (count_d == 4'd0);
        full_d   = (count_d == 4'd8);
        aempty_d = (int'(count_d) <= ALMOST_EMPTY_VALUE);
        afull_d  = ((DEPTH - int'(count_d)) <= ALMOST_FULL_VALUE);
    end

    // NOTE: storage has no reset; once the pointers clear, old words are unreachable and need no scrubbing.
    always_ff @(posedge CLK) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_word;
    end

    // NOTE: state registers use non-blocking assignments so every one samples its pre-edge value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b0;
            q_nib_q  <= '0;
            q_byte_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            phase_q  <= phase_d;
            q_nib_q  <= q_nib_d;
            q_byte_q <= q_byte_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            aempty_q <= aempty_d;
            afull_q  <= afull_d;
        end
    end

    assign fifo.Q0 = q_nib_q[0];
    assign fifo.Q1 = q_nib_q[1];
    assign fifo.Q2 = q_nib_q[2];
    assign fifo.Q3 = q_nib_q[3];
    assign fifo.Q4 = q_nib_q[4];
    assign fifo.Q5 = q_byte_q[0];
    assign fifo.Q6 = q_byte_q[1];
    assign fifo.Q7 = q_nib_q[5];
    assign fifo.Q8 = q_nib_q[6];
    assign fifo.Q9 = q_nib_q[7];

    assign fifo.EMPTY       = empty_q;
    assign fifo.FULL        = full_q;
    assign fifo.ALMOSTEMPTY = aempty_q;
    assign fifo.ALMOSTFULL  = afull_q;

`ifdef SIP_OUT_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo.WREN && full_q)  overflow_q  <= 1'b1;
            if (fifo.RDEN && empty_q) underflow_q <= 1'b1;
        end
    end

    assign fifo.OVERFLOW  = overflow_q;
    assign fifo.UNDERFLOW = underflow_q;
`endif

endmodule

// File: tb/tb_sip_out_fifo.sv
// Directed bench for sip_out_fifo: four instances cover 4_X_4, 8_X_4, ALMOST_EMPTY_VALUE=2 and OUTPUT_DISABLE.
// Sticky error-flag sequences are included when SIP_OUT_FIFO_ERR_FLAGS_EN is defined.
module tb_sip_out_fifo;

    logic clk;
    logic rst_n;

    sip_out_fifo_if if_a ();
    sip_out_fifo_if if_b ();
    sip_out_fifo_if if_c ();
    sip_out_fifo_if if_d ();

    sip_out_fifo #(.ARRAY_MODE("4_X_4")) u_a (.CLK(clk), .RESET_N(rst_n), .fifo(if_a));
    sip_out_fifo #(.ARRAY_MODE("8_X_4")) u_b (.CLK(clk), .RESET_N(rst_n), .fifo(if_b));
    sip_out_fifo #(.ARRAY_MODE("4_X_4"), .ALMOST_EMPTY_VALUE(2)) u_c (.CLK(clk), .RESET_N(rst_n), .fifo(if_c));
    sip_out_fifo #(.ARRAY_MODE("4_X_4"), .OUTPUT_DISABLE("TRUE")) u_d (.CLK(clk), .RESET_N(rst_n), .fifo(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       wren;
        logic       rden;
        logic [7:0] d0;
        logic [7:0] d5;
        logic [3:0] q0;
        logic [7:0] q5;
        logic       empty;
        logic       full;
        logic       aempty;
        logic       afull;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic r, input logic [7:0] d0, input logic [7:0] d5,
                                input logic [3:0] q0, input logic [7:0] q5,
                                input logic e, input logic f, input logic ae, input logic af);
        vec_t v;
        v.wren = w;  v.rden = r;  v.d0 = d0;  v.d5 = d5;
        v.q0 = q0;   v.q5 = q5;   v.empty = e; v.full = f; v.aempty = ae; v.afull = af;
        return v;
    endfunction

    vec_t       vecs [19];
    logic [7:0] model [$];
    logic [7:0] exp_b;

    initial begin
        // 4_X_4 ordering, write-while-full with a concurrent read, read-while-empty, read+write on empty
        vecs[0]  = mk(1, 0, 8'h10, 8'h10, 4'h0, 8'h00, 0, 0, 1, 0);
        vecs[1]  = mk(1, 0, 8'h11, 8'h11, 4'h0, 8'h00, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 8'h12, 8'h12, 4'h0, 8'h00, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 8'h13, 8'h13, 4'h0, 8'h00, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 8'h14, 8'h14, 4'h0, 8'h00, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 8'h15, 8'h15, 4'h0, 8'h00, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 8'h16, 8'h16, 4'h0, 8'h00, 0, 0, 0, 1);
        vecs[7]  = mk(1, 0, 8'h17, 8'h17, 4'h0, 8'h00, 0, 1, 0, 1);
        vecs[8]  = mk(1, 1, 8'hEE, 8'hEE, 4'h0, 8'h10, 0, 0, 0, 1);
        vecs[9]  = mk(0, 1, 8'h00, 8'h00, 4'h1, 8'h11, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'h00, 8'h00, 4'h2, 8'h12, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 8'h00, 8'h00, 4'h3, 8'h13, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 8'h00, 8'h00, 4'h4, 8'h14, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 8'h00, 8'h00, 4'h5, 8'h15, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 8'h00, 8'h00, 4'h6, 8'h16, 0, 0, 1, 0);
        vecs[15] = mk(0, 1, 8'h00, 8'h00, 4'h7, 8'h17, 1, 0, 1, 0);
        vecs[16] = mk(0, 1, 8'h00, 8'h00, 4'h7, 8'h17, 1, 0, 1, 0);
        vecs[17] = mk(1, 1, 8'h3B, 8'h4C, 4'h7, 8'h17, 0, 0, 1, 0);
        vecs[18] = mk(0, 1, 8'h00, 8'h00, 4'hB, 8'h4C, 1, 0, 1, 0);

        rst_n = 1'b1;
        if_a.WREN = 0; if_a.RDEN = 0;
        if_b.WREN = 0; if_b.RDEN = 0;
        if_c.WREN = 0; if_c.RDEN = 0;
        if_d.WREN = 0; if_d.RDEN = 0;
        {if_a.D0, if_a.D1, if_a.D2, if_a.D3, if_a.D4, if_a.D5, if_a.D6, if_a.D7, if_a.D8, if_a.D9} = '0;
        {if_b.D0, if_b.D1, if_b.D2, if_b.D3, if_b.D4, if_b.D5, if_b.D6, if_b.D7, if_b.D8, if_b.D9} = '0;
        {if_c.D0, if_c.D1, if_c.D2, if_c.D3, if_c.D4, if_c.D5, if_c.D6, if_c.D7, if_c.D8, if_c.D9} = '0;
        {if_d.D0, if_d.D1, if_d.D2, if_d.D3, if_d.D4, if_d.D5, if_d.D6, if_d.D7, if_d.D8, if_d.D9} = '0;

        // Power-on reset, checked before the first clock edge
        #1 rst_n = 1'b0;
        #2;
        check("por EMPTY", if_a.EMPTY, 1'b1);
        check("por ALMOSTEMPTY", if_a.ALMOSTEMPTY, 1'b1);
        check("por FULL", if_a.FULL, 1'b0);
        check("por ALMOSTFULL", if_a.ALMOSTFULL, 1'b0);
        check("por Q0", if_a.Q0, 4'h0);
        check("por Q5", if_a.Q5, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            if_a.WREN = vecs[i].wren;
            if_a.RDEN = vecs[i].rden;
            if_a.D0   = vecs[i].d0;
            if_a.D5   = vecs[i].d5;
            tick();
            check($sformatf("v%0d Q0", i), if_a.Q0, vecs[i].q0);
            check($sformatf("v%0d Q5", i), if_a.Q5, vecs[i].q5);
            check($sformatf("v%0d EMPTY", i), if_a.EMPTY, vecs[i].empty);
            check($sformatf("v%0d FULL", i), if_a.FULL, vecs[i].full);
            check($sformatf("v%0d ALMOSTEMPTY", i), if_a.ALMOSTEMPTY, vecs[i].aempty);
            check($sformatf("v%0d ALMOSTFULL", i), if_a.ALMOSTFULL, vecs[i].afull);
        end
        if_a.WREN = 0; if_a.RDEN = 0;

        // 8_X_4 nibble split on instance B
        if_b.D0 = 8'hA5; if_b.D5 = 8'h3C; if_b.D6 = 8'hF1; if_b.D9 = 8'h96;
        if_b.WREN = 1;
        tick();
        if_b.WREN = 0;
        check("b wr EMPTY", if_b.EMPTY, 1'b0);
        if_b.RDEN = 1;
        tick();
        check("b beat1 Q0", if_b.Q0, 4'h5);
        check("b beat1 Q5", if_b.Q5, 8'h0C);
        check("b beat1 Q6", if_b.Q6, 8'h01);
        check("b beat1 Q9", if_b.Q9, 4'h6);
        check("b beat1 EMPTY", if_b.EMPTY, 1'b0);
        tick();
        check("b beat2 Q0", if_b.Q0, 4'hA);
        check("b beat2 Q5", if_b.Q5, 8'h03);
        check("b beat2 Q6", if_b.Q6, 8'h0F);
        check("b beat2 Q9", if_b.Q9, 4'h9);
        check("b beat2 EMPTY", if_b.EMPTY, 1'b1);
        tick();
        check("b rd empty Q0 hold", if_b.Q0, 4'hA);
        if_b.RDEN = 0;

        // Wrap and concurrency on A: hold 4 words across 20 simultaneous write/read cycles
        if_a.D0 = 8'h07;
        for (int k = 0; k < 4; k++) begin
            if_a.D5 = 8'h40 + 8'(k);
            if_a.WREN = 1;
            tick();
            model.push_back(8'h40 + 8'(k));
        end
        for (int c = 0; c < 20; c++) begin
            if_a.D5 = 8'h60 + 8'(c);
            if_a.WREN = 1;
            if_a.RDEN = 1;
            tick();
            exp_b = model.pop_front();
            model.push_back(8'h60 + 8'(c));
            check($sformatf("wrap c%0d Q5", c), if_a.Q5, exp_b);
            check($sformatf("wrap c%0d EMPTY", c), if_a.EMPTY, 1'b0);
            check($sformatf("wrap c%0d FULL", c), if_a.FULL, 1'b0);
            check($sformatf("wrap c%0d ALMOSTEMPTY", c), if_a.ALMOSTEMPTY, 1'b0);
        end
        if_a.WREN = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_b = model.pop_front();
            check($sformatf("drain %0d Q5", k), if_a.Q5, exp_b);
            check($sformatf("drain %0d EMPTY", k), if_a.EMPTY, model.size() == 0);
        end
        if_a.RDEN = 0;

        // ALMOST_EMPTY_VALUE=2 threshold on instance C
        for (int k = 1; k <= 3; k++) begin
            if_c.D5 = 8'(k);
            if_c.WREN = 1;
            tick();
            check($sformatf("c count%0d ALMOSTEMPTY", k), if_c.ALMOSTEMPTY, k <= 2);
        end
        if_c.WREN = 0;
        if_c.RDEN = 1;
        tick();
        if_c.RDEN = 0;
        check("c read Q5", if_c.Q5, 8'h01);
        check("c count2 ALMOSTEMPTY", if_c.ALMOSTEMPTY, 1'b1);

        // OUTPUT_DISABLE on instance D
        {if_d.D0, if_d.D5, if_d.D6, if_d.D9} = '1;
        if_d.WREN = 1;
        tick();
        if_d.WREN = 0;
        check("d wr EMPTY", if_d.EMPTY, 1'b0);
        if_d.RDEN = 1;
        tick();
        if_d.RDEN = 0;
        check("d Q0", if_d.Q0, 4'h0);
        check("d Q5", if_d.Q5, 8'h00);
        check("d Q6", if_d.Q6, 8'h00);
        check("d Q9", if_d.Q9, 4'h0);
        check("d EMPTY", if_d.EMPTY, 1'b1);

        // Reset mid-transfer with A full and Q holding data
        for (int k = 0; k < 8; k++) begin
            if_a.D5 = 8'h80 + 8'(k);
            if_a.WREN = 1;
            tick();
        end
        if_a.WREN = 0;
        check("pre-rst FULL", if_a.FULL, 1'b1);
        check("pre-rst Q5", if_a.Q5, 8'h73);
        if_a.RDEN = 1;
        #1 rst_n = 1'b0;
        #1;
        check("rst EMPTY", if_a.EMPTY, 1'b1);
        check("rst ALMOSTEMPTY", if_a.ALMOSTEMPTY, 1'b1);
        check("rst FULL", if_a.FULL, 1'b0);
        check("rst ALMOSTFULL", if_a.ALMOSTFULL, 1'b0);
        check("rst Q0", if_a.Q0, 4'h0);
        check("rst Q5", if_a.Q5, 8'h00);
        check("rst b Q0", if_b.Q0, 4'h0);
`ifdef SIP_OUT_FIFO_ERR_FLAGS_EN
        check("rst OVERFLOW", if_a.OVERFLOW, 1'b0);
        check("rst UNDERFLOW", if_a.UNDERFLOW, 1'b0);
`endif
        if_a.RDEN = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        if_a.RDEN = 1;
        tick();
        if_a.RDEN = 0;
        check("post-rst read Q5", if_a.Q5, 8'h00);
        check("post-rst EMPTY", if_a.EMPTY, 1'b1);

`ifdef SIP_OUT_FIFO_ERR_FLAGS_EN
        // A is empty here, so the read above already counts as an underflow
        check("UNDERFLOW set", if_a.UNDERFLOW, 1'b1);
        check("OVERFLOW clear", if_a.OVERFLOW, 1'b0);
        if_a.WREN = 1;
        for (int k = 0; k < 9; k++) tick();
        if_a.WREN = 0;
        check("OVERFLOW set", if_a.OVERFLOW, 1'b1);
        if_a.RDEN = 1;
        tick();
        tick();
        if_a.RDEN = 0;
        check("OVERFLOW sticky", if_a.OVERFLOW, 1'b1);
        check("UNDERFLOW sticky", if_a.UNDERFLOW, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
